mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
Bus-master counterpart to the team's single-port RAM. It drives the RAM's wr_rdn/addr/w_data pins and consumes its combinational r_data to perform block copy or block fill operations without CPU involvement. It sits beside the PDUA core and shares the data RAM through an external arbiter, which is outside this block. One word is moved per 2 cycles in copy mode and per cycle in fill mode.

Parameters:
DATA_WIDTH, 8, word width; must equal the RAM's DATA_WIDTH.
ADDR_WIDTH, 8, address width; must equal the RAM's ADDR_WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
start  in  1  command strobe, sampled only in IDLE
mode  in  1  0 = copy, 1 = fill
src_addr  in  ADDR_WIDTH  copy source base
dst_addr  in  ADDR_WIDTH  destination base
len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
fill_data  in  DATA_WIDTH  fill pattern
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse at completion
mem_wr_rdn  out  1  RAM write enable; high only in WRITE
mem_addr  out  ADDR_WIDTH  RAM address
mem_w_data  out  DATA_WIDTH  RAM write data
mem_r_data  in  DATA_WIDTH  RAM combinational read data

Behaviour:
- One clock domain. rst is synchronous and active-high.
- Reset forces state IDLE. Outputs at reset: busy=0, done=0, mem_wr_rdn=0, mem_addr=0, mem_w_data=0. Pointers, count, and the data register clear to 0.
- rst asserted mid-operation aborts at the next edge. No further writes occur and no done pulse is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1:
  - Latch mode, fill_data, and the pointers.
  - Load cnt=len.
  - Choose the direction.
  - If len=0, go to DONE. Else if mode=copy, go to READ. Else go to WRITE.
- Direction rule, copy only:
  - diff = (dst_addr - src_addr) mod 2**ADDR_WIDTH.
  - If diff != 0 and diff < len, run descending. Pointers start at src+len-1 and dst+len-1 (mod 2**ADDR_WIDTH).
  - Otherwise run ascending from the base addresses.
  - Fill mode is always ascending.
- READ (one cycle):
  - mem_addr = src pointer, mem_wr_rdn = 0.
  - Capture mem_r_data into the data register at the edge.
  - Next state WRITE.
- WRITE (one cycle):
  - mem_addr = dst pointer, mem_wr_rdn = 1.
  - mem_w_data = data register in copy mode, latched fill_data in fill mode.
  - At the edge: cnt decrements and pointers step by ±1, wrapping mod 2**ADDR_WIDTH.
  - If cnt was 1, go to DONE. Else go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- In IDLE and DONE: mem_wr_rdn=0 and mem_addr holds its last value.
- start while not IDLE is ignored. Inputs other than mem_r_data are don't-care after acceptance.
- Latency from the start-accept edge, counted in busy cycles:
  - copy N words: 2N+1
  - fill N words: N+1
  - len=0: 1 (DONE only, no memory write)
- Pointers wrap silently. len=2**ADDR_WIDTH touches every location exactly once.
- mem_wr_rdn must never glitch high outside WRITE. It is decoded from registered state only.

Decomposition:
- Package mem_copy_pkg holds:
  - state encoding: IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3
  - mode constants: MODE_COPY=1'b0, MODE_FILL=1'b1
- One natural sub-module, mcp_addr_gen. It holds one pointer register with load, step-enable, and direction inputs, applying wrap-around arithmetic. It is instantiated twice, once for src and once for dst.
- The FSM, counter, and data register stay in the top module.

Test Plan:
- Copy, non-overlapping. Preload RAM[0x10..0x13]=A0..A3; start mode=0 src=0x10 dst=0x40 len=4 -> 4 writes ascending to 0x40..0x43 with A0..A3; done at busy cycle 9; source unchanged.
- Overlap, descending. RAM[0x20..0x24]=1..5; copy src=0x20 dst=0x22 len=5 -> writes go to 0x26 down to 0x22; final RAM[0x22..0x26]=1..5 with no corruption.
- Fill with wrap-around. fill_data=0x5A, dst=0xFE, len=4 -> writes to 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles; done on the 5th busy cycle.
- len=0, plus start while busy. len=0 gives a done pulse 1 cycle after start with mem_wr_rdn never high. A second start pulsed during a copy len=3 is ignored, and exactly 3 writes occur.
- Reset mid-copy. Start copy len=8 and assert rst after the 3rd write -> next cycle busy=0, done=0, mem_wr_rdn=0; exactly 3 destination words modified; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared encodings for the memory copy/fill engine.
package mem_copy_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mcp_addr_gen.sv
// Single wrapping address pointer with load, step and direction control.
module mcp_addr_gen #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_val,
   input  logic                  step,
   input  logic                  down,
   output logic [ADDR_WIDTH-1:0] ptr
);

   // Pointer register; load wins over step, arithmetic wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (step) begin
         ptr <= down ? ptr - ADDR_WIDTH'(1) : ptr + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy / block fill bus master for the single-port data RAM.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic [DATA_WIDTH-1:0] fill_data,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_wr_rdn,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic [DATA_WIDTH-1:0] mem_r_data
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

   state_t                state;
   logic                  mode_q;
   logic                  down_q;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [ADDR_WIDTH-1:0] src_ptr;
   logic [ADDR_WIDTH-1:0] dst_ptr;

   logic                  accept_c;
   logic                  desc_c;
   logic [ADDR_WIDTH-1:0] len_lo_c;
   logic [ADDR_WIDTH-1:0] diff_c;
   logic [ADDR_WIDTH-1:0] src_init_c;
   logic [ADDR_WIDTH-1:0] dst_init_c;
   logic [ADDR_WIDTH-1:0] dst_load_c;

   // Command acceptance and copy direction: descend when the destination
   // starts inside the source window so unread source words are not clobbered.
   assign accept_c   = (state == IDLE) && start;
   assign len_lo_c   = len[ADDR_WIDTH-1:0];
   assign diff_c     = dst_addr - src_addr;
   assign desc_c     = (mode == MODE_COPY) && (diff_c != '0) && ({1'b0, diff_c} < len);
   assign src_init_c = desc_c ? src_addr + len_lo_c - ADDR_WIDTH'(1) : src_addr;
   assign dst_init_c = desc_c ? dst_addr + len_lo_c - ADDR_WIDTH'(1) : dst_addr;
   // Fill issues the first write straight from the command, so its pointer starts one ahead.
   assign dst_load_c = (mode == MODE_FILL) ? dst_addr + ADDR_WIDTH'(1) : dst_init_c;

   // Source pointer advances once its word has been read.
   mcp_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_src (
      .clk      (clk),
      .rst      (rst),
      .load     (accept_c),
      .load_val (src_init_c),
      .step     (state == READ),
      .down     (down_q),
      .ptr      (src_ptr)
   );

   // Destination pointer advances on every write.
   mcp_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst (
      .clk      (clk),
      .rst      (rst),
      .load     (accept_c),
      .load_val (dst_load_c),
      .step     (state == WRITE),
      .down     (down_q),
      .ptr      (dst_ptr)
   );

   // FSM with registered bus outputs; mem_w_data doubles as the data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_wr_rdn <= 1'b0;
         mem_addr   <= '0;
         mem_w_data <= '0;
         cnt        <= '0;
         mode_q     <= MODE_COPY;
         down_q     <= 1'b0;
      end else begin
         done       <= 1'b0;
         mem_wr_rdn <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  cnt    <= len;
                  mode_q <= mode;
                  down_q <= desc_c;
                  if (mode == MODE_FILL) begin
                     mem_w_data <= fill_data;
                  end
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (mode == MODE_COPY) begin
                     state    <= READ;
                     mem_addr <= src_init_c;
                  end else begin
                     state      <= WRITE;
                     mem_addr   <= dst_addr;
                     mem_wr_rdn <= 1'b1;
                  end
               end
            end
            READ: begin
               mem_w_data <= mem_r_data;
               state      <= WRITE;
               mem_addr   <= dst_ptr;
               mem_wr_rdn <= 1'b1;
            end
            WRITE: begin
               cnt <= cnt - CNT_WIDTH'(1);
               if (cnt == CNT_WIDTH'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (mode_q == MODE_COPY) begin
                  state    <= READ;
                  mem_addr <= src_ptr;
               end else begin
                  state      <= WRITE;
                  mem_addr   <= dst_ptr;
                  mem_wr_rdn <= 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
